gcd_arbiter: RTL
================

// Module: gcd_arbiter
// PURPOSE
//  Shares one gcd datapath unit among N_REQ requesters. Round-robin selects one
//  pending request, latches its operands, pulses gcd_start, waits for
//  gcd_res_rdy, pulses gcd_res_fetch and returns the result to the granted
//  requester over a valid/ready response. Sits between client blocks and the gcd.
// PARAMETERS
//  N_REQ    4    number of requesters (2..16)
//  W        8    operand/result width; must equal gcd datapath width
//  TIMEOUT  255  WAIT-state cycle limit (used only with GCD_ARB_TIMEOUT_EN)
// PORTS
//  clk            in   1        clock, all logic on rising edge
//  rst            in   1        synchronous reset, active-high
//  req_vld        in   N_REQ    per-requester request valid
//  req_a          in   N_REQ*W  operand a, requester i at [i*W +: W]
//  req_b          in   N_REQ*W  operand b, same packing
//  req_rdy        out  N_REQ    one-hot accept pulse; handshake = vld & rdy
//  rsp_vld        out  N_REQ    one-hot (or zero) response valid
//  rsp_res        out  W        result for requester flagged in rsp_vld
//  rsp_err        out  1        timeout flag, qualified by rsp_vld
//  rsp_rdy        in   N_REQ    per-requester response ready
//  gcd_start      out  1        start pulse to gcd unit
//  gcd_a, gcd_b   out  W        operands to gcd unit
//  gcd_res_rdy    in   1        gcd result ready
//  gcd_res        in   W        gcd result
//  gcd_res_fetch  out  1        result-consumed pulse to gcd unit
//  busy           out  1        high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; rr pointer last=N_REQ-1 (req 0 wins first).
//    Integration drives gcd rst_n = ~rst; reset mid-operation aborts with no response.
//  - FSM states: IDLE, ISSUE, WAIT, RESP.
//  - IDLE: if |req_vld, grant g = first set bit searching from last+1 (wrapping);
//    req_rdy[g]=1 this cycle; latch req_a/req_b[g] into gcd_a/gcd_b; -> ISSUE.
//  - ISSUE: gcd_start=1 for exactly one cycle; -> WAIT.
//  - WAIT: on gcd_res_rdy=1: latch gcd_res, gcd_res_fetch=1 that cycle; -> RESP.
//  - RESP: rsp_vld[g]=1, rsp_res stable until rsp_rdy[g]=1; on handshake
//    last=g, -> IDLE.
//  - gcd_a/gcd_b hold latched values from grant until the next grant.
//  - Requesters hold a/b stable while req_vld=1 and req_rdy=0. Dropping
//    req_vld before grant is legal.
//  - Requests during busy stall (req_rdy=0). Min 4 cycles + gcd latency per op.
//  - Operands are passed through uninterpreted (zeros included).
//  - rsp_rdy of non-granted requesters is ignored. At most one req_rdy and one
//    rsp_vld bit high in any cycle.
// CONFIGURATION
//  GCD_ARB_TIMEOUT_EN defined:
//   - WAIT counter clears on entry. When it reaches TIMEOUT with no
//     gcd_res_rdy, go to RESP with rsp_res=0 and rsp_err=1.
//   - In IDLE, an unexpected gcd_res_rdy=1 gets a one-cycle gcd_res_fetch and
//     is discarded. This drains a late result.
//   - While draining, a grant is not issued that cycle.
//  GCD_ARB_TIMEOUT_EN undefined:
//   - No counter; WAIT waits indefinitely; rsp_err tied 0.
//   - gcd_res_rdy is ignored outside WAIT.
// TESTING
//  1. Req0 (60,48), rsp_rdy=1: req_rdy[0] pulses; gcd_start next cycle;
//     fetch coincides with res_rdy; rsp_vld[0] with rsp_res=12.
//  2. Req0,1,2 raised together after reset with (30,24),(17,5),(100,75):
//     grants in order 0,1,2; results 6, 1, 25; rsp_err=0 each time.
//  3. Req0 and req3 held high over 6 ops: grants alternate 0,3,0,3,0,3.
//  4. rsp_rdy[1] low 5 cycles in RESP: rsp_vld[1] and rsp_res held;
//     no gcd_start or req_rdy until the handshake.
//  5. rst=1 for one cycle during WAIT: all outputs 0 next cycle. Then req2 and
//     req0 together: req0 granted first.
//  6. Macro on, TIMEOUT=8, gcd model silent: after 8 WAIT cycles rsp_vld with
//     rsp_res=0 and rsp_err=1. Late res_rdy in IDLE: one fetch pulse, no response.

Source files
------------

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that time-shares one gcd datapath among N_REQ requesters.
// Optional WAIT timeout and late-result drain are enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_vld,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic [N_REQ-1:0]     req_rdy,
    output logic [N_REQ-1:0]     rsp_vld,
    output logic [W-1:0]         rsp_res,
    output logic                 rsp_err,
    input  logic [N_REQ-1:0]     rsp_rdy,
    output logic                 gcd_start,
    output logic [W-1:0]         gcd_a,
    output logic [W-1:0]         gcd_b,
    input  logic                 gcd_res_rdy,
    input  logic [W-1:0]         gcd_res,
    output logic                 gcd_res_fetch,
    output logic                 busy
);
    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 1) begin : g_param_check
        $error("gcd_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;

    logic [IW-1:0] last, grant, pick, rr_idx;
    logic          found, grant_now, rsp_hs, drain, timeout_hit;
    logic [W-1:0]  res_q, sel_a, sel_b;

    // First pending request after the last served one, wrapping around.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        rr_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            rr_idx = IW'((int'(last) + i) % N_REQ);
            if (!found && req_vld[rr_idx]) begin
                found = 1'b1;
                pick  = rr_idx;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == IW'(i)) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err_q;

    // A result arriving while idle is stale (its request already timed out).
    assign drain       = (state == IDLE) && gcd_res_rdy;
    assign timeout_hit = (state == WAIT) && !gcd_res_rdy && (cnt == CW'(TIMEOUT - 1));
    assign rsp_err     = !rst && (state == RESP) && err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            if (state == WAIT && gcd_res_rdy) err_q <= 1'b0;
            else if (timeout_hit)             err_q <= 1'b1;
        end
    end
`else
    assign drain       = 1'b0;
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    assign grant_now = (state == IDLE) && found && !drain;
    assign rsp_hs    = (state == RESP) && rsp_rdy[grant];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_now) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (gcd_res_rdy || timeout_hit) state_nx = RESP;
            RESP:    if (rsp_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_rdy       = '0;
        rsp_vld       = '0;
        rsp_res       = '0;
        gcd_start     = 1'b0;
        gcd_res_fetch = 1'b0;
        busy          = 1'b0;
        if (!rst) begin
            if (grant_now) req_rdy[pick] = 1'b1;
            gcd_start     = (state == ISSUE);
            gcd_res_fetch = ((state == WAIT) && gcd_res_rdy) || drain;
            busy          = (state != IDLE);
            if (state == RESP) begin
                rsp_vld[grant] = 1'b1;
                rsp_res        = res_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last  <= IW'(N_REQ - 1);
            grant <= '0;
            gcd_a <= '0;
            gcd_b <= '0;
            res_q <= '0;
        end else begin
            if (grant_now) begin
                grant <= pick;
                gcd_a <= sel_a;
                gcd_b <= sel_b;
            end
            if (state == WAIT && gcd_res_rdy) res_q <= gcd_res;
            else if (timeout_hit)             res_q <= '0;
            if (rsp_hs) last <= grant;
        end
    end
endmodule
